counter_sweep_controller: RTL and testbench
===========================================

COUNTER_SWEEP_CONTROLLER -- requirements
Module: counter_sweep_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100000000: clock cycles per hold tick (1 s at 100 MHz).
REQ-002 SHALL have parameter HOLD_TICKS, default 2: hold ticks spent at each limit.
REQ-003 SHALL have port CLK, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port START, input, 1: asynchronous start/resume button.
REQ-006 SHALL have port STOP, input, 1: asynchronous pause/abort button.
REQ-007 SHALL have port MODE, input, 1: 1 = continuous sweeping, 0 = single sweep.
REQ-008 SHALL have port UPPER_LIMIT, input, 8: sweep top value.
REQ-009 SHALL have port LOWER_LIMIT, input, 8: sweep bottom value.
REQ-010 SHALL have port VALUE, input, 8: counter value fed back from the up/down counter LEDS output.
REQ-011 SHALL have port CTR_ENABLE, output, 1: drives the counter enable.
REQ-012 SHALL have port CTR_CNTRL, output, 1: drives the counter direction (1 = up).
REQ-013 SHALL have port STATE, output, 3: current state encoding.
REQ-014 SHALL have port CYCLE_COUNT, output, 8: completed sweep cycles.
REQ-015 SHALL have port FAULT, output, 1: high while in FAULT.

Function
REQ-016 SHALL pass START and STOP through a 2-flop synchroniser plus rising-edge detector, giving 1-cycle pulses start_p and stop_p 3 cycles after the input rises.
REQ-017 SHALL implement states IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4, PAUSED=5, FAULT=6, with all outputs registered.
REQ-018 In IDLE, start_p SHALL clear CYCLE_COUNT and go to FAULT if UPPER_LIMIT <= LOWER_LIMIT, else go to UP.
REQ-019 In UP, VALUE >= UPPER_LIMIT SHALL cause a transition to HOLD_HI; >= covers overshoot.
REQ-020 In HOLD_HI, hold expiry SHALL cause a transition to DOWN.
REQ-021 In DOWN, VALUE <= LOWER_LIMIT SHALL cause a transition to HOLD_LO.
REQ-022 In HOLD_LO, hold expiry SHALL increment CYCLE_COUNT, saturating at 255, then go to UP if MODE=1 or IDLE if MODE=0; MODE is sampled at expiry.
REQ-023 The prescaler SHALL be zero on entry to either HOLD state and count 0..TICK_DIV-1 only in HOLD states; hold expiry SHALL occur on the cycle the HOLD_TICKS-th tick completes.
REQ-024 In UP, DOWN, HOLD_HI or HOLD_LO, stop_p SHALL save the current state and go to PAUSED; the prescaler and tick count are frozen.
REQ-025 In PAUSED, start_p SHALL resume the saved state with its timers intact, and stop_p SHALL go to IDLE.
REQ-026 In FAULT, stop_p SHALL go to IDLE, and start_p SHALL be ignored.
REQ-027 Simultaneous start_p and stop_p SHALL be treated as stop_p only.
REQ-028 CTR_ENABLE SHALL be 1 only in UP and DOWN.
REQ-029 CTR_CNTRL SHALL be 1 in UP and 0 in DOWN, and SHALL hold its last value in all other states.
REQ-030 Limit changes mid-sweep SHALL take effect at the next comparison with no restart; only IDLE checks for FAULT.

Reset
REQ-031 RESET low SHALL immediately force state IDLE, CTR_ENABLE=0, CTR_CNTRL=1, CYCLE_COUNT=0, FAULT=0, and clear the prescaler, tick counter, saved state and synchronisers.
REQ-032 Reset mid-operation SHALL abandon any sweep or pause, and after release the controller SHALL require a fresh start_p.

Structure
REQ-033 State encodings and TICK_DIV/HOLD_TICKS defaults SHALL live in a shared package header used by this block and its bench.
REQ-034 Synchroniser plus edge detector SHALL be one sub-module, button_pulse_sync, instantiated twice.
REQ-035 No other sub-modules; FSM, prescaler and cycle counter in counter_sweep_controller.

Verification (TICK_DIV=4, HOLD_TICKS=2, counter model in bench)
REQ-036 Single sweep: LOWER=2, UPPER=5, MODE=0, start from VALUE=2 -> UP until VALUE=5, HOLD_HI 8 cycles with ENABLE=0, DOWN to 2, HOLD_LO 8 cycles, IDLE, CYCLE_COUNT=1.
REQ-037 Continuous: MODE=1, 3 full sweeps -> CYCLE_COUNT=3, with CTR_CNTRL toggling at each limit.
REQ-038 Fault: UPPER=3, LOWER=3, START -> FAULT=1, STATE=6, ENABLE=0; START ignored; STOP -> IDLE, FAULT=0.
REQ-039 Pause: STOP during HOLD_HI after 1 tick -> PAUSED, ENABLE=0; START -> HOLD_HI, expiring after 4 more cycles.
REQ-040 Collision/reset: START and STOP rising same cycle in UP -> PAUSED; RESET low during DOWN -> IDLE immediately, CTR_CNTRL=1, CYCLE_COUNT=0.
REQ-041 Saturation: force 260 cycles with MODE=1 and HOLD_TICKS=1 -> CYCLE_COUNT remains 255.

Source files
------------

// File: rtl/counter_sweep_controller_pkg.sv
// Shared definitions for the sweep controller: state codes, timing defaults, state helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package counter_sweep_controller_pkg;

  // Timing defaults: one hold tick per second at 100 MHz, two ticks per limit.
  localparam int TICK_DIV_DEFAULT   = 100000000;
  localparam int HOLD_TICKS_DEFAULT = 2;

  // State encodings, visible on the STATE output.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_UP      = 3'd1;
  localparam logic [2:0] ST_HOLD_HI = 3'd2;
  localparam logic [2:0] ST_DOWN    = 3'd3;
  localparam logic [2:0] ST_HOLD_LO = 3'd4;
  localparam logic [2:0] ST_PAUSED  = 3'd5;
  localparam logic [2:0] ST_FAULT   = 3'd6;

  // True in either dwell state at a sweep limit.
  function automatic logic is_hold(input logic [2:0] s);
    return (s == ST_HOLD_HI) || (s == ST_HOLD_LO);
  endfunction

  // True while the external counter is being driven.
  function automatic logic is_moving(input logic [2:0] s);
    return (s == ST_UP) || (s == ST_DOWN);
  endfunction

endpackage

// File: rtl/button_pulse_sync.sv
// Button conditioner: 2-flop synchroniser plus rising-edge detector, one-cycle pulse out.
// Latency: pulse is high 3 clock edges after the button input first samples high.
// Backpressure: none; a held button yields exactly one pulse until released.
// Ports: clk (rising edge), rst_n (async active-low), btn_in (async level), pulse (1-cycle, registered).
module button_pulse_sync
  import counter_sweep_controller_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse
);

  // sync_q[0], sync_q[1] form the synchroniser; sync_q[2] is the previous
  // synchronised level used for edge detection.
  logic [2:0] sync_q, sync_d;
  logic       pulse_q, pulse_d;

  always_comb begin
    sync_d  = {sync_q[1:0], btn_in};
    pulse_d = sync_q[1] & ~sync_q[2];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 3'b000;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/counter_sweep_controller.sv
// Sweeps an external up/down counter between two limits with a timed dwell at each end.
// Latency: buttons act 4 edges after rising; limit compares act 1 edge after VALUE; outputs registered.
// Backpressure: none; STOP beats START when both pulse together, START is ignored in FAULT.
// Ports: CLK, RESET (async active-low), START/STOP (async buttons), MODE (1 = continuous),
//        UPPER_LIMIT/LOWER_LIMIT/VALUE (8-bit), CTR_ENABLE/CTR_CNTRL (counter drive),
//        STATE (3-bit code), CYCLE_COUNT (completed sweeps, saturating), FAULT.
module counter_sweep_controller
  import counter_sweep_controller_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEFAULT,
  parameter int HOLD_TICKS = HOLD_TICKS_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       STOP,
  input  logic       MODE,
  input  logic [7:0] UPPER_LIMIT,
  input  logic [7:0] LOWER_LIMIT,
  input  logic [7:0] VALUE,
  output logic       CTR_ENABLE,
  output logic       CTR_CNTRL,
  output logic [2:0] STATE,
  output logic [7:0] CYCLE_COUNT,
  output logic       FAULT
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TICK_W  = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [TICK_W-1:0]  TICK_MAX  = TICK_W'(HOLD_TICKS - 1);

  logic start_p, stop_p;

  button_pulse_sync u_start_sync (
    .clk    (CLK),
    .rst_n  (RESET),
    .btn_in (START),
    .pulse  (start_p)
  );

  button_pulse_sync u_stop_sync (
    .clk    (CLK),
    .rst_n  (RESET),
    .btn_in (STOP),
    .pulse  (stop_p)
  );

  logic [2:0]         state_q, state_d;
  logic [2:0]         saved_q, saved_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [TICK_W-1:0]  tick_q, tick_d;
  logic [7:0]         cycle_q, cycle_d;
  logic               ctr_enable_q, ctr_enable_d;
  logic               ctr_cntrl_q, ctr_cntrl_d;
  logic               fault_q, fault_d;
  logic               presc_wrap, hold_expire;

  always_comb begin
    state_d     = state_q;
    saved_d     = saved_q;
    presc_d     = presc_q;
    tick_d      = tick_q;
    cycle_d     = cycle_q;
    presc_wrap  = (presc_q == PRESC_MAX);
    hold_expire = presc_wrap && (tick_q == TICK_MAX);

    if (stop_p) begin
      // STOP wins any collision with START.
      case (state_q)
        ST_UP, ST_HOLD_HI, ST_DOWN, ST_HOLD_LO: begin
          saved_d = state_q;
          state_d = ST_PAUSED;
        end
        ST_PAUSED, ST_FAULT: state_d = ST_IDLE;
        default:             state_d = ST_IDLE;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_p) begin
            cycle_d = 8'd0;
            state_d = (UPPER_LIMIT <= LOWER_LIMIT) ? ST_FAULT : ST_UP;
          end
        end
        // Limits are read live, so a mid-sweep change applies at the next compare.
        ST_UP:   if (VALUE >= UPPER_LIMIT) state_d = ST_HOLD_HI;
        ST_DOWN: if (VALUE <= LOWER_LIMIT) state_d = ST_HOLD_LO;
        ST_HOLD_HI, ST_HOLD_LO: begin
          if (presc_wrap) begin
            presc_d = '0;
            tick_d  = hold_expire ? '0 : tick_q + TICK_W'(1);
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
          if (hold_expire) begin
            if (state_q == ST_HOLD_HI) begin
              state_d = ST_DOWN;
            end else begin
              if (cycle_q != 8'hFF) cycle_d = cycle_q + 8'd1;
              state_d = MODE ? ST_UP : ST_IDLE;
            end
          end
        end
        ST_PAUSED: if (start_p) state_d = saved_q;
        ST_FAULT:  state_d = ST_FAULT;
        default:   state_d = ST_IDLE;
      endcase
    end

    // Hold timers survive only in the hold states and across a pause; everywhere
    // else they sit at zero so every hold entry starts a fresh dwell.
    if (!is_hold(state_d) && (state_d != ST_PAUSED)) begin
      presc_d = '0;
      tick_d  = '0;
    end

    // Outputs are decoded from the next state so they register alongside it.
    ctr_enable_d = is_moving(state_d);
    ctr_cntrl_d  = ctr_cntrl_q;
    if (state_d == ST_UP)   ctr_cntrl_d = 1'b1;
    if (state_d == ST_DOWN) ctr_cntrl_d = 1'b0;
    fault_d      = (state_d == ST_FAULT);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      saved_q      <= ST_IDLE;
      presc_q      <= '0;
      tick_q       <= '0;
      cycle_q      <= 8'd0;
      ctr_enable_q <= 1'b0;
      ctr_cntrl_q  <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      saved_q      <= saved_d;
      presc_q      <= presc_d;
      tick_q       <= tick_d;
      cycle_q      <= cycle_d;
      ctr_enable_q <= ctr_enable_d;
      ctr_cntrl_q  <= ctr_cntrl_d;
      fault_q      <= fault_d;
    end
  end

  assign STATE       = state_q;
  assign CYCLE_COUNT = cycle_q;
  assign CTR_ENABLE  = ctr_enable_q;
  assign CTR_CNTRL   = ctr_cntrl_q;
  assign FAULT       = fault_q;

endmodule

// File: tb/tb_counter_sweep_controller.sv
// Bench for the sweep controller: external counter model, dwell-time model, directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
module tb_counter_sweep_controller;
  import counter_sweep_controller_pkg::*;

  localparam int TD       = 4;
  localparam int HT       = 2;
  localparam int HOLD_LEN = TD * HT;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       MODE = 1'b0;
  logic [7:0] UPPER_LIMIT = 8'd5;
  logic [7:0] LOWER_LIMIT = 8'd2;
  logic [7:0] VALUE = 8'd2;
  logic       CTR_ENABLE, CTR_CNTRL, FAULT;
  logic [2:0] STATE;
  logic [7:0] CYCLE_COUNT;

  logic       start2 = 1'b0;
  logic [7:0] value2 = 8'd2;
  logic       en2, dir2, fault2;
  logic [2:0] state2;
  logic [7:0] cc2;

  always #5 CLK = ~CLK;

  counter_sweep_controller #(.TICK_DIV(TD), .HOLD_TICKS(HT)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .STOP(STOP), .MODE(MODE),
    .UPPER_LIMIT(UPPER_LIMIT), .LOWER_LIMIT(LOWER_LIMIT), .VALUE(VALUE),
    .CTR_ENABLE(CTR_ENABLE), .CTR_CNTRL(CTR_CNTRL), .STATE(STATE),
    .CYCLE_COUNT(CYCLE_COUNT), .FAULT(FAULT)
  );

  counter_sweep_controller #(.TICK_DIV(TD), .HOLD_TICKS(1)) dut_sat (
    .CLK(CLK), .RESET(RESET), .START(start2), .STOP(1'b0), .MODE(1'b1),
    .UPPER_LIMIT(8'd3), .LOWER_LIMIT(8'd2), .VALUE(value2),
    .CTR_ENABLE(en2), .CTR_CNTRL(dir2), .STATE(state2),
    .CYCLE_COUNT(cc2), .FAULT(fault2)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // External up/down counters closing the loop on VALUE.
  logic       ld = 1'b0;
  logic [7:0] ld_val = 8'd0;
  always @(posedge CLK) begin
    if (ld) VALUE <= ld_val;
    else if (CTR_ENABLE) VALUE <= CTR_CNTRL ? VALUE + 8'd1 : VALUE - 8'd1;
    if (en2) value2 <= dir2 ? value2 + 8'd1 : value2 - 8'd1;
  end

  // Behavioural model: button acts when seen high 3 edges ago and low 4 edges ago;
  // each hold is a countdown of HOLD_LEN hold cycles that simply stops while paused.
  int       m_state = ST_IDLE;
  int       m_saved = ST_IDLE;
  int       m_left = 0;
  int       m_cycles = 0;
  int       m_en = 0;
  int       m_dir = 1;
  int       m_fault = 0;
  logic [3:0] st_h = 4'b0;
  logic [3:0] sp_h = 4'b0;
  logic     m_start_p, m_stop_p;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      m_state = ST_IDLE; m_saved = ST_IDLE; m_left = 0; m_cycles = 0;
      m_en = 0; m_dir = 1; m_fault = 0; st_h = 4'b0; sp_h = 4'b0;
    end else begin
      m_start_p = st_h[2] & ~st_h[3];
      m_stop_p  = sp_h[2] & ~sp_h[3];
      st_h = {st_h[2:0], START};
      sp_h = {sp_h[2:0], STOP};
      if (m_stop_p) begin
        if (m_state == ST_UP || m_state == ST_DOWN || m_state == ST_HOLD_HI || m_state == ST_HOLD_LO) begin
          m_saved = m_state;
          m_state = ST_PAUSED;
        end else if (m_state == ST_PAUSED || m_state == ST_FAULT) begin
          m_state = ST_IDLE;
        end
      end else if (m_state == ST_IDLE) begin
        if (m_start_p) begin
          m_cycles = 0;
          m_state  = (UPPER_LIMIT <= LOWER_LIMIT) ? ST_FAULT : ST_UP;
        end
      end else if (m_state == ST_PAUSED) begin
        if (m_start_p) m_state = m_saved;
      end else if (m_state == ST_UP) begin
        if (VALUE >= UPPER_LIMIT) begin m_state = ST_HOLD_HI; m_left = HOLD_LEN; end
      end else if (m_state == ST_DOWN) begin
        if (VALUE <= LOWER_LIMIT) begin m_state = ST_HOLD_LO; m_left = HOLD_LEN; end
      end else if (m_state == ST_HOLD_HI || m_state == ST_HOLD_LO) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          if (m_state == ST_HOLD_HI) m_state = ST_DOWN;
          else begin
            if (m_cycles < 255) m_cycles = m_cycles + 1;
            m_state = MODE ? ST_UP : ST_IDLE;
          end
        end
      end
      m_en    = (m_state == ST_UP || m_state == ST_DOWN) ? 1 : 0;
      if (m_state == ST_UP)   m_dir = 1;
      if (m_state == ST_DOWN) m_dir = 0;
      m_fault = (m_state == ST_FAULT) ? 1 : 0;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge CLK) begin
    check("state",       int'(STATE),       m_state);
    check("ctr_enable",  int'(CTR_ENABLE),  m_en);
    check("ctr_cntrl",   int'(CTR_CNTRL),   m_dir);
    check("cycle_count", int'(CYCLE_COUNT), m_cycles);
    check("fault",       int'(FAULT),       m_fault);
  end

  // Saturation-instance monitor: completed sweeps and any decrease of its count.
  int         sweeps2 = 0;
  logic [2:0] prev_s2 = ST_IDLE;
  logic [7:0] prev_cc2 = 8'd0;
  bit         drop2 = 1'b0;
  always @(negedge CLK) begin
    if (prev_s2 == ST_HOLD_LO && state2 != ST_HOLD_LO) sweeps2++;
    if (RESET && cc2 < prev_cc2) drop2 = 1'b1;
    prev_s2  = state2;
    prev_cc2 = cc2;
  end

  task automatic press(input bit is_stop);
    if (is_stop) STOP = 1'b1; else START = 1'b1;
    repeat (2) @(negedge CLK);
    STOP  = 1'b0;
    START = 1'b0;
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int budget);
    int i;
    i = 0;
    while (STATE != s && i < budget) begin
      @(negedge CLK);
      i++;
    end
    check({name, "_reached"}, int'(STATE), int'(s));
  endtask

  task automatic measure(input logic [2:0] s, output int n, output bit en_seen);
    n = 0;
    en_seen = 1'b0;
    while (STATE == s && n < 100) begin
      if (CTR_ENABLE) en_seen = 1'b1;
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic load(input logic [7:0] v);
    ld_val = v;
    ld = 1'b1;
    @(negedge CLK);
    ld = 1'b0;
  endtask

  initial begin
    int n;
    bit en_seen;
    int toggles;
    logic prev_dir;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_state",  int'(STATE), 0);
    check("rst_enable", int'(CTR_ENABLE), 0);
    check("rst_cntrl",  int'(CTR_CNTRL), 1);
    check("rst_cycles", int'(CYCLE_COUNT), 0);
    check("rst_fault",  int'(FAULT), 0);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);

    // Single sweep 2..5
    press(0);
    wait_state("single_up", ST_UP, 10);
    check("single_up_enable", int'(CTR_ENABLE), 1);
    wait_state("single_hold_hi", ST_HOLD_HI, 30);
    measure(ST_HOLD_HI, n, en_seen);
    check("hold_hi_cycles", n, 8);
    check("hold_hi_enable_seen", int'(en_seen), 0);
    check("down_cntrl", int'(CTR_CNTRL), 0);
    wait_state("single_hold_lo", ST_HOLD_LO, 30);
    measure(ST_HOLD_LO, n, en_seen);
    check("hold_lo_cycles", n, 8);
    check("single_end_state", int'(STATE), 0);
    check("single_cycles", int'(CYCLE_COUNT), 1);

    // Continuous, three sweeps
    MODE = 1'b1;
    press(0);
    prev_dir = CTR_CNTRL;
    toggles = 0;
    n = 0;
    while (CYCLE_COUNT != 8'd3 && n < 600) begin
      @(negedge CLK);
      n++;
      if (CTR_CNTRL != prev_dir) toggles++;
      prev_dir = CTR_CNTRL;
    end
    check("cont_cycles", int'(CYCLE_COUNT), 3);
    check("cont_state", int'(STATE), 1);
    check("cont_toggles", toggles, 7);
    press(1);
    wait_state("cont_paused", ST_PAUSED, 10);
    check("cont_paused_enable", int'(CTR_ENABLE), 0);
    press(1);
    wait_state("cont_abort", ST_IDLE, 10);

    // Fault on equal limits
    MODE = 1'b0;
    UPPER_LIMIT = 8'd3;
    LOWER_LIMIT = 8'd3;
    press(0);
    wait_state("fault", ST_FAULT, 10);
    check("fault_flag", int'(FAULT), 1);
    check("fault_enable", int'(CTR_ENABLE), 0);
    press(0);
    repeat (8) @(negedge CLK);
    check("fault_ignores_start", int'(STATE), 6);
    press(1);
    wait_state("fault_clear", ST_IDLE, 10);
    check("fault_cleared", int'(FAULT), 0);

    // Pause in HOLD_HI after one tick, resume with timers intact
    UPPER_LIMIT = 8'd5;
    LOWER_LIMIT = 8'd2;
    load(8'd2);
    press(0);
    wait_state("pause_hold_hi", ST_HOLD_HI, 30);
    @(negedge CLK);
    STOP = 1'b1;
    repeat (2) @(negedge CLK);
    STOP = 1'b0;
    wait_state("pause", ST_PAUSED, 10);
    check("pause_enable", int'(CTR_ENABLE), 0);
    press(0);
    wait_state("resume_hold_hi", ST_HOLD_HI, 10);
    measure(ST_HOLD_HI, n, en_seen);
    check("resume_hold_cycles", n, 4);
    wait_state("pause_sweep_end", ST_IDLE, 60);
    check("pause_sweep_cycles", int'(CYCLE_COUNT), 1);

    // START/STOP collision in UP, limit change mid-sweep, reset in DOWN
    UPPER_LIMIT = 8'd200;
    load(8'd2);
    press(0);
    wait_state("coll_up", ST_UP, 10);
    START = 1'b1;
    STOP  = 1'b1;
    repeat (2) @(negedge CLK);
    START = 1'b0;
    STOP  = 1'b0;
    wait_state("coll_paused", ST_PAUSED, 10);
    press(0);
    wait_state("coll_resume_up", ST_UP, 10);
    UPPER_LIMIT = 8'd10;
    wait_state("coll_down", ST_DOWN, 60);
    #3 RESET = 1'b0;
    #1;
    check("async_rst_state",  int'(STATE), 0);
    check("async_rst_enable", int'(CTR_ENABLE), 0);
    check("async_rst_cntrl",  int'(CTR_CNTRL), 1);
    check("async_rst_cycles", int'(CYCLE_COUNT), 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    repeat (10) @(negedge CLK);
    check("no_restart_after_reset", int'(STATE), 0);

    // Saturation on the single-tick instance
    start2 = 1'b1;
    repeat (2) @(negedge CLK);
    start2 = 1'b0;
    n = 0;
    while (sweeps2 < 260 && n < 10000) begin
      @(negedge CLK);
      n++;
    end
    check("sat_sweeps_done", int'(sweeps2 >= 260), 1);
    check("sat_cycle_count", int'(cc2), 255);
    check("sat_no_wrap", int'(drop2), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
